// File: rtl/vga_timing.sv
// Raster timing generator: pixel/line counters, syncs, active-video flag and
// line/frame strobes. Counters and frame count are registers; every other
// output is a zero-latency combinational decode of them.
module vga_timing #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pixelEnable,
    output logic [9:0] colPos,
    output logic [9:0] rowPos,
    output logic       displayActive,
    output logic       hsync,
    output logic       vsync,
    output logic       lineEnd,
    output logic       frameStart,
    output logic [7:0] frameCount
);

    // Totals must not exceed 1024 so that every count fits in 10 bits.
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Decode bounds kept 11 bits wide so a window ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START  = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START  = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END    = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0]  col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic [7:0]  frame_q, frame_d;
    logic [10:0] col_ext, row_ext;
    logic        h_active, v_active;
    logic        h_sync_win, v_sync_win;

    // Next-state: column advances on enabled cycles, row on column wrap, frame on row wrap.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        frame_d = frame_q;
        if (pixelEnable) begin
            if (col_q == H_LAST) begin
                col_d = '0;
                if (row_q == V_LAST) begin
                    row_d   = '0;
                    frame_d = frame_q + 8'd1;
                end else begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    // Counter registers; reset abandons the current frame without counting it.
    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            frame_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            frame_q <= frame_d;
        end
    end

    // Output decodes; reset forces the idle values (active, syncs high, no strobes).
    always_comb begin
        col_ext    = {1'b0, col_q};
        row_ext    = {1'b0, row_q};
        h_active   = col_ext < H_VIS_END;
        v_active   = row_ext < V_VIS_END;
        h_sync_win = (col_ext >= HS_START) && (col_ext < HS_END);
        v_sync_win = (row_ext >= VS_START) && (row_ext < VS_END);

        displayActive = reset | (h_active & v_active);
        hsync         = reset | ~h_sync_win;
        vsync         = reset | ~v_sync_win;
        lineEnd       = ~reset & (col_q == H_LAST);
        frameStart    = ~reset & (col_q == 10'd0) & (row_q == 10'd0);
    end

    assign colPos     = col_q;
    assign rowPos     = row_q;
    assign frameCount = frame_q;

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing: a small-geometry instance exercises whole
// frames and frame-count wrap, a default 640x480 instance checks one real line.
module tb_vga_timing;

    // Small geometry: 12 pixels x 9 lines = 108 cycles per frame.
    localparam int unsigned SHV = 6;
    localparam int unsigned SHF = 2;
    localparam int unsigned SHS = 2;
    localparam int unsigned SHB = 2;
    localparam int unsigned SVV = 4;
    localparam int unsigned SVF = 1;
    localparam int unsigned SVS = 2;
    localparam int unsigned SVB = 2;
    localparam int unsigned SHT = SHV + SHF + SHS + SHB;
    localparam int unsigned SVT = SVV + SVF + SVS + SVB;
    localparam int unsigned SFRAME = SHT * SVT;

    logic       clk;
    logic       reset;
    logic       pixelEnable;

    logic [9:0] s_col, s_row, d_col, d_row;
    logic [7:0] s_fc, d_fc;
    logic       s_da, s_hs, s_vs, s_le, s_fs;
    logic       d_da, d_hs, d_vs, d_le, d_fs;
    logic [32:0] s_vec, d_vec;

    int     checks = 0;
    int     passed = 0;
    longint t = 0;  // enabled cycles since last reset

    vga_timing #(
        .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
    ) u_small (
        .clk(clk), .reset(reset), .pixelEnable(pixelEnable),
        .colPos(s_col), .rowPos(s_row), .displayActive(s_da), .hsync(s_hs),
        .vsync(s_vs), .lineEnd(s_le), .frameStart(s_fs), .frameCount(s_fc)
    );

    vga_timing u_dflt (
        .clk(clk), .reset(reset), .pixelEnable(pixelEnable),
        .colPos(d_col), .rowPos(d_row), .displayActive(d_da), .hsync(d_hs),
        .vsync(d_vs), .lineEnd(d_le), .frameStart(d_fs), .frameCount(d_fc)
    );

    assign s_vec = {s_col, s_row, s_fc, s_da, s_hs, s_vs, s_le, s_fs};
    assign d_vec = {d_col, d_row, d_fc, d_da, d_hs, d_vs, d_le, d_fs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: position is simply the enabled-cycle count folded by line and frame sizes.
    function automatic logic [32:0] model_out(input longint hv, input longint hf,
                                              input longint hs, input longint hb,
                                              input longint vv, input longint vf,
                                              input longint vs, input longint vb,
                                              input longint tt, input logic rst);
        longint ht, vt, col, row, fc;
        logic   da, hsy, vsy, le, fs;
        logic [9:0] c10, r10;
        logic [7:0] f8;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        col = tt % ht;
        row = (tt / ht) % vt;
        fc  = (tt / (ht * vt)) % 256;
        da  = rst || (col < hv && row < vv);
        hsy = rst || !(col >= hv + hf && col < hv + hf + hs);
        vsy = rst || !(row >= vv + vf && row < vv + vf + vs);
        le  = !rst && (col == ht - 1);
        fs  = !rst && (col == 0) && (row == 0);
        c10 = col[9:0];
        r10 = row[9:0];
        f8  = fc[7:0];
        return {c10, r10, f8, da, hsy, vsy, le, fs};
    endfunction

    function automatic logic [32:0] exp_s();
        return model_out(SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, t, reset);
    endfunction

    function automatic logic [32:0] exp_d();
        return model_out(640, 16, 96, 48, 480, 10, 2, 33, t, reset);
    endfunction

    // One clock: update the model with the inputs seen at the edge, then settle.
    task automatic tick();
        @(posedge clk);
        if (reset) t = 0;
        else if (pixelEnable) t = t + 1;
        #1;
    endtask

    task automatic restart();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [32:0] idle;
        idle = {10'd0, 10'd0, 8'd0, 5'b11100};
        reset = 1'b1;
        pixelEnable = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (s_vec !== idle) $display("FAIL reset_hold_s: got %h expected %h", s_vec, idle);
            else passed++;
            checks++;
            if (d_vec !== idle) $display("FAIL reset_hold_d: got %h expected %h", d_vec, idle);
            else passed++;
        end
        reset = 1'b0;
        #1;
        checks++;
        if (s_vec !== {10'd0, 10'd0, 8'd0, 5'b11101})
            $display("FAIL release_s: got %h expected frameStart=1 at (0,0)", s_vec);
        else passed++;
        checks++;
        if (d_vec !== {10'd0, 10'd0, 8'd0, 5'b11101})
            $display("FAIL release_d: got %h expected frameStart=1 at (0,0)", d_vec);
        else passed++;
        tick();
        checks++;
        if (d_vec !== {10'd1, 10'd0, 8'd0, 5'b11100})
            $display("FAIL after_release_d: got %h expected col=1 frameStart=0", d_vec);
        else passed++;
    endtask

    task automatic test_line();
        int act, hs_cnt, hs_first, hs_last, le_cnt, le_col;
        act = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; le_cnt = 0; le_col = -1;
        pixelEnable = 1'b1;
        restart();
        for (int i = 0; i < 800; i++) begin
            if (d_da) act++;
            if (!d_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_col);
                hs_last = int'(d_col);
            end
            if (d_le) begin
                le_cnt++;
                le_col = int'(d_col);
            end
            tick();
        end
        checks++;
        if (act !== 640) $display("FAIL line_active: got %0d expected 640", act);
        else passed++;
        checks++;
        if (hs_cnt !== 96) $display("FAIL line_hsync_len: got %0d expected 96", hs_cnt);
        else passed++;
        checks++;
        if (hs_first !== 656) $display("FAIL line_hsync_first: got %0d expected 656", hs_first);
        else passed++;
        checks++;
        if (hs_last !== 751) $display("FAIL line_hsync_last: got %0d expected 751", hs_last);
        else passed++;
        checks++;
        if (le_cnt !== 1 || le_col !== 799)
            $display("FAIL line_end: got %0d pulses at col %0d expected 1 at 799", le_cnt, le_col);
        else passed++;
        checks++;
        if (d_row !== 10'd1 || d_col !== 10'd0)
            $display("FAIL line_wrap: got (%0d,%0d) expected (0,1)", d_col, d_row);
        else passed++;
    endtask

    task automatic test_random();
        bit s_bad, d_bad;
        s_bad = 0; d_bad = 0;
        restart();
        for (int i = 0; i < 700; i++) begin
            reset = ($urandom_range(0, 99) < 2);
            pixelEnable = ($urandom_range(0, 3) != 0);
            tick();
            if (!s_bad) begin
                checks++;
                if (s_vec !== exp_s()) begin
                    $display("FAIL random_s cyc %0d: got %h expected %h", i, s_vec, exp_s());
                    s_bad = 1;
                end else passed++;
            end
            if (!d_bad) begin
                checks++;
                if (d_vec !== exp_d()) begin
                    $display("FAIL random_d cyc %0d: got %h expected %h", i, d_vec, exp_d());
                    d_bad = 1;
                end else passed++;
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_frame();
        int n, vs_low, le_cnt;
        n = 0; vs_low = 0; le_cnt = 0;
        pixelEnable = 1'b1;
        restart();
        while (n < 1000) begin
            tick();
            n++;
            if (!s_vs) vs_low++;
            if (s_le) le_cnt++;
            if (s_fs) break;
        end
        checks++;
        if (n !== int'(SFRAME)) $display("FAIL frame_period: got %0d expected %0d", n, SFRAME);
        else passed++;
        checks++;
        if (vs_low !== int'(SVS * SHT))
            $display("FAIL frame_vsync_len: got %0d expected %0d", vs_low, SVS * SHT);
        else passed++;
        checks++;
        if (le_cnt !== int'(SVT)) $display("FAIL frame_lineend: got %0d expected %0d", le_cnt, SVT);
        else passed++;
        checks++;
        if (s_fc !== 8'd1) $display("FAIL frame_count_inc: got %0d expected 1", s_fc);
        else passed++;
    endtask

    task automatic test_enable_toggle();
        logic [3:0] pat;
        int n, k;
        bit prev, bad;
        pat = 4'b1001;
        n = 0; k = 0; prev = 1; bad = 0;
        restart();
        while (n < 2000) begin
            pixelEnable = pat[k % 4];
            k++;
            tick();
            n++;
            if (!bad) begin
                checks++;
                if (s_vec !== exp_s()) begin
                    $display("FAIL toggle_track: got %h expected %h", s_vec, exp_s());
                    bad = 1;
                end else passed++;
            end
            if (s_fs && !prev) break;
            prev = s_fs;
        end
        checks++;
        if (n !== int'(2 * SFRAME))
            $display("FAIL toggle_period: got %0d expected %0d", n, 2 * SFRAME);
        else passed++;
        // Strobe must persist while the counters are held.
        pixelEnable = 1'b0;
        tick();
        tick();
        checks++;
        if (s_fs !== 1'b1 || s_col !== 10'd0)
            $display("FAIL toggle_hold: got fs=%0b col=%0d expected fs=1 col=0", s_fs, s_col);
        else passed++;
    endtask

    task automatic test_mid_reset();
        pixelEnable = 1'b1;
        restart();
        repeat (3 * SHT + 5) tick();
        checks++;
        if (s_vec !== {10'd5, 10'd3, 8'd0, 5'b11100})
            $display("FAIL mid_pos: got %h expected (5,3)", s_vec);
        else passed++;
        reset = 1'b1;
        tick();
        checks++;
        if (s_vec !== {10'd0, 10'd0, 8'd0, 5'b11100})
            $display("FAIL mid_reset: got %h expected (0,0) idle", s_vec);
        else passed++;
        reset = 1'b0;
        #1;
        repeat (SFRAME - 1) tick();
        checks++;
        if (s_vec !== {10'd11, 10'd8, 8'd0, 5'b01110})
            $display("FAIL last_pixel: got %h expected (11,8) lineEnd", s_vec);
        else passed++;
        reset = 1'b1;
        #1;
        checks++;
        if (s_vec !== {10'd11, 10'd8, 8'd0, 5'b11100})
            $display("FAIL reset_forces: got %h expected strobes low", s_vec);
        else passed++;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (s_vec !== {10'd0, 10'd0, 8'd0, 5'b11101})
            $display("FAIL no_frame_inc: got %h expected (0,0) count 0", s_vec);
        else passed++;
    endtask

    task automatic test_wrap();
        int total;
        bit bad;
        total = int'(SFRAME) * 256;
        bad = 0;
        pixelEnable = 1'b1;
        restart();
        for (int i = 0; i < total; i++) begin
            tick();
            if (!bad) begin
                checks++;
                if (s_vec !== exp_s()) begin
                    $display("FAIL wrap_track cyc %0d: got %h expected %h", i, s_vec, exp_s());
                    bad = 1;
                end else passed++;
            end
            if (i == total - 2) begin
                checks++;
                if (s_fc !== 8'd255) $display("FAIL wrap_pre: got %0d expected 255", s_fc);
                else passed++;
            end
        end
        checks++;
        if (s_vec !== {10'd0, 10'd0, 8'd0, 5'b11101})
            $display("FAIL wrap_zero: got %h expected (0,0) count 0 frameStart", s_vec);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        pixelEnable = 1'b0;
        test_reset();
        test_line();
        test_random();
        test_frame();
        test_enable_toggle();
        test_mid_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
